multiplier_4x4_core: RTL and testbench
======================================

# multiplier_4x4_core

Unsigned 4-bit by 4-bit multiplier that produces an 8-bit product. It uses a registered structural array: AND-gate partial products feed ripple rows of half/full adders. Inputs and outputs are registered, with a valid flag travelling alongside the data. It serves as a fully pipelined arithmetic leaf accepting one operand pair per clock.

## Interface
- No parameters; widths fixed at 4x4 -> 8.
- clk  input  1  single system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  A/B valid this cycle.
- A  input  4  multiplicand, unsigned.
- B  input  4  multiplier, unsigned.
- out_valid  output  1  R holds a new product this cycle.
- R  output  8  product A*B, unsigned.

## Operation
- Stage 0 (input register):
  - On a rising clk edge with in_valid=1, capture A, B into a_q, b_q and set v0=1.
  - With in_valid=0, v0 is cleared and a_q/b_q hold their previous values.
- Combinational array from a_q, b_q:
  - Partial products pp[i][j] = a_q[j] & b_q[i].
  - Row 0 is pp[0]; rows 1..3 are each added into the shifted running sum through a 4-bit ripple of half/full adders.
  - Total cells: 12 adder cells (4 HA + 8 FA), built as separate half_adder/full_adder instances.
  - R[0] = pp[0][0]; every bit is exact, with no truncation or rounding.
- Stage 1 (output register):
  - On each rising edge, out_valid <= v0.
  - When v0=1, R <= array product; when v0=0, R holds its last value.
- The arithmetic is exact. The maximum product is 15*15 = 225 (0xE1), which fits in 8 bits, so overflow is impossible.
- There is no backpressure. Every accepted pair yields exactly one out_valid pulse.

## Timing
- Reset (asynchronous assert, release synchronous to clk):
  - a_q=0, b_q=0, v0=0, out_valid=0, R=8'h00 immediately on rst_n falling.
- Latency: 2 clocks. A pair sampled at edge n appears on R with out_valid=1 after edge n+1.
- Throughput: 1 pair per clock. Back-to-back in_valid produces back-to-back out_valid with products in input order.
- Gaps in in_valid produce matching gaps in out_valid; R is stable during the gaps.
- Reset mid-operation: all in-flight pairs are discarded. out_valid stays 0 until a pair is sampled after reset release.
- Inputs are sampled only at clk edges. Changes to A/B between edges have no effect.

## Configuration
- MULTIPLIER4X4_PIPE_EN defined:
  - Adds a mid-array register after adder row 1. It captures the partial sum, pp rows 2..3 inputs (a_q, b_q) and v0.
  - This register resets to 0 asynchronously like the others.
  - Latency becomes 3 clocks; throughput stays 1/clock.
- MULTIPLIER4X4_PIPE_EN undefined: no mid-array register; latency 2 clocks as specified above.
- Products are identical in both builds.

## Test plan
- Reset: hold rst_n=0 while driving A=4'hF, B=4'hF, in_valid=1 -> R=8'h00 and out_valid=0 throughout. The first valid output appears 2 clocks (3 with PIPE_EN) after release.
- Directed vectors, one per cycle with in_valid=1: A=0,B=10 -> R=0; A=5,B=10 -> R=50 (0x32); A=6,B=9 -> R=54 (0x36). Results must emerge in order on consecutive cycles.
- Extremes: A=15,B=15 -> R=225 (0xE1); A=15,B=1 -> R=15; A=1,B=0 -> R=0.
- Gaps: in_valid pattern 1,0,1 with pairs (3,4),(x,x),(7,7) -> out_valid 1,0,1 with R=12, held at 12, then 49.
- Reset mid-flight: sample (5,5), then assert rst_n=0 before its output -> no out_valid pulse for 25. R=0 immediately on assertion.
- Exhaustive: all 256 pairs streamed back-to-back -> every R equals A*B at correct latency. Run with MULTIPLIER4X4_PIPE_EN both defined and undefined.

Source files
------------

// File: rtl/multiplier_4x4_core.sv
// multiplier_4x4_core
//   Unsigned 4x4 -> 8 pipelined array multiplier. Operands are registered,
//   AND-gate partial products feed three ripple rows of half/full adders
//   (4 HA + 8 FA), and the product is registered with a valid flag.
//   Optional macro MULTIPLIER4X4_PIPE_EN inserts a mid-array register after
//   adder row 1 (latency 3 instead of 2).
// Ports:
//   clk       rising-edge clock
//   rst_n     async active-low reset
//   in_valid  A/B valid this cycle
//   A, B      4-bit unsigned operands
//   out_valid R holds a new product this cycle
//   R         8-bit unsigned product

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module multiplier_4x4_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       out_valid,
  output logic [7:0] R
);

  // Stage 0 operand register
  logic [3:0] a_q, a_d, b_q, b_d;
  logic       v0_q, v0_d;
  // Stage 1 output register
  logic [7:0] r_q, r_d;
  logic       out_valid_q, out_valid_d;

  // Rows 0..1 partial products, from the stage-0 operands
  logic [1:0][3:0] pp;
  assign pp[0] = a_q & {4{b_q[0]}};
  assign pp[1] = a_q & {4{b_q[1]}};

  // Adder row 1: pp[1] + (pp[0] >> 1). Top input is 0, so bits 0 and 3 are HAs.
  logic [3:0] s1, c1;
  half_adder u_r1_b0 (.a(pp[1][0]), .b(pp[0][1]), .s(s1[0]), .c(c1[0]));
  full_adder u_r1_b1 (.a(pp[1][1]), .b(pp[0][2]), .ci(c1[0]), .s(s1[1]), .co(c1[1]));
  full_adder u_r1_b2 (.a(pp[1][2]), .b(pp[0][3]), .ci(c1[1]), .s(s1[2]), .co(c1[2]));
  half_adder u_r1_b3 (.a(pp[1][3]), .b(c1[2]), .s(s1[3]), .c(c1[3]));

  // Signals feeding rows 2..3: either straight through or via the mid register
  logic [3:0] acc_in;   // running sum entering row 2 (already shifted)
  logic [1:0] lo_in;    // finished product bits [1:0]
  logic [3:0] a_hi, b_hi;
  logic       v_arr;    // valid aligned with the array output

`ifdef MULTIPLIER4X4_PIPE_EN
  logic [3:0] acc_q, acc_d, am_q, am_d, bm_q, bm_d;
  logic [1:0] lo_q, lo_d;
  logic       vm_q, vm_d;

  always_comb begin
    acc_d = {c1[3], s1[3:1]};
    lo_d  = {s1[0], pp[0][0]};
    am_d  = a_q;
    bm_d  = b_q;
    vm_d  = v0_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      lo_q  <= '0;
      am_q  <= '0;
      bm_q  <= '0;
      vm_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      am_q  <= am_d;
      bm_q  <= bm_d;
      vm_q  <= vm_d;
    end
  end

  always_comb begin
    acc_in = acc_q;
    lo_in  = lo_q;
    a_hi   = am_q;
    b_hi   = bm_q;
    v_arr  = vm_q;
  end
`else
  always_comb begin
    acc_in = {c1[3], s1[3:1]};
    lo_in  = {s1[0], pp[0][0]};
    a_hi   = a_q;
    b_hi   = b_q;
    v_arr  = v0_q;
  end
`endif

  // Adder rows 2..3: pp[r+2] + running sum. Each row retires one product bit
  // and passes {carry, sum[3:1]} down as the next shifted running sum.
  logic [2:0][3:0] acc_row;
  logic [1:0]      lo_row;
  assign acc_row[0] = acc_in;

  for (genvar r = 0; r < 2; r++) begin : g_row
    logic [3:0] pph, s, c;
    assign pph = a_hi & {4{b_hi[r+2]}};
    half_adder u_b0 (.a(pph[0]), .b(acc_row[r][0]), .s(s[0]), .c(c[0]));
    for (genvar j = 1; j < 4; j++) begin : g_fa
      full_adder u_fa (.a(pph[j]), .b(acc_row[r][j]), .ci(c[j-1]), .s(s[j]), .co(c[j]));
    end
    assign acc_row[r+1] = {c[3], s[3:1]};
    assign lo_row[r]    = s[0];
  end

  logic [7:0] prod;
  assign prod = {acc_row[2], lo_row, lo_in};

  always_comb begin
    a_d         = in_valid ? A : a_q;
    b_d         = in_valid ? B : b_q;
    v0_d        = in_valid;
    out_valid_d = v_arr;
    r_d         = v_arr ? prod : r_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      v0_q        <= 1'b0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      v0_q        <= v0_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign R         = r_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_4x4_core.sv
// Self-checking bench for multiplier_4x4_core: directed, gap, reset and
// exhaustive/random streams checked against a queue-based reference of
// products due at a fixed latency.
module tb_multiplier_4x4_core;

`ifdef MULTIPLIER4X4_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A, B;
  logic       out_valid;
  logic [7:0] R;

  multiplier_4x4_core dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
    .out_valid(out_valid), .R(R)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [7:0] p; } exp_t;
  exp_t       q[$];
  int         edge_n = 0;
  logic [7:0] hold = 8'h00;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%02h) expected %0d (0x%02h) at edge %0d",
               tag, got, got, exp, exp, edge_n);
    end
  endtask

  // One clock: drive inputs, take the edge, then check against the model.
  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b, input string tag);
    exp_t e;
    in_valid = v; A = a; B = b;
    @(posedge clk);
    edge_n++;
    if (v && rst_n) begin
      e.due = edge_n + LAT - 1;
      e.p   = 8'(int'(a) * int'(b));
      q.push_back(e);
    end
    @(negedge clk);
    if (q.size() > 0 && q[0].due == edge_n) begin
      hold = q[0].p;
      void'(q.pop_front());
      chk({tag, "_vld"}, {7'd0, out_valid}, 8'd1);
    end else begin
      chk({tag, "_vld"}, {7'd0, out_valid}, 8'd0);
    end
    chk({tag, "_R"}, R, hold);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 4'($urandom), 4'($urandom), tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    hold = 8'h00;
  endtask

  initial begin
    do_reset();
    in_valid = 1'b1; A = 4'hF; B = 4'hF;
    #1;
    chk("rst_R0", R, 8'h00);
    chk("rst_vld0", {7'd0, out_valid}, 8'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'hF, 4'hF, "rst_hold");
    rst_n = 1'b1;

    // Directed, back-to-back
    step(1'b1, 4'd0, 4'd10, "dir");
    step(1'b1, 4'd5, 4'd10, "dir");
    step(1'b1, 4'd6, 4'd9,  "dir");
    // Extremes
    step(1'b1, 4'd15, 4'd15, "ext");
    step(1'b1, 4'd15, 4'd1,  "ext");
    step(1'b1, 4'd1,  4'd0,  "ext");
    drain("ext_drain");

    // Gap pattern 1,0,1
    step(1'b1, 4'd3, 4'd4, "gap");
    step(1'b0, 4'($urandom), 4'($urandom), "gap");
    step(1'b1, 4'd7, 4'd7, "gap");
    drain("gap_drain");

    // Reset mid-flight
    step(1'b1, 4'd5, 4'd5, "mid");
    do_reset();
    #1;
    chk("mid_rst_R", R, 8'h00);
    chk("mid_rst_vld", {7'd0, out_valid}, 8'd0);
    step(1'b1, 4'd9, 4'd9, "mid_in_rst");
    rst_n = 1'b1;
    drain("mid_after");

    // Exhaustive, back-to-back
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step(1'b1, 4'(a), 4'(b), "exh");
    drain("exh_drain");

    // Random valid/data
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), "rnd");
    drain("rnd_drain");

    if (q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL leftover: %0d expected products never emerged", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
